// File: rtl/mc_controller_if.sv
// mc_controller_if
// Shared memory-port bundle between the multi-cycle controller and the memory.
// The controller is the master: it raises mem_req (qualified by mem_we) and
// picks the address source with addr_sel. The memory answers with mem_ready
// and, for reads, mem_rdata.
//   mem_req    master->slave  access request, held until mem_ready is seen
//   mem_we     master->slave  write qualifier for mem_req
//   addr_sel   master->slave  address source: 0 = PC, 1 = ALU result
//   mem_ready  slave->master  access completes this cycle
//   mem_rdata  slave->master  read data, valid while mem_ready=1
interface mc_controller_if;

   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;

   modport master (
      output mem_req,
      output mem_we,
      output addr_sel,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  addr_sel,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/mc_controller.sv
// mc_controller
// Multi-cycle controller for the MIPS-subset datapath. Each instruction
// walks BOOT/FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory
// port. The controller owns the instruction register, drives per-state
// datapath enables, waits on memory handshakes, watches for a stalled bus and
// traps precisely on illegal opcodes, bus timeouts and (optionally) overflow.
//
// Parameters
//   TIMEOUT   maximum cycles spent waiting for mem_ready in one FETCH/MEM visit
//   OVF_TRAP  1 = ADD/SUB/ADDI overflow traps, 0 = it only suppresses rf_we
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          memory port (master side of mc_controller_if)
//   overflow     ALU overflow, valid in EXEC
//   branch_taken branch condition, valid in EXEC
//   ir           latched instruction
//   pc_we        PC write enable
//   pc_src       next PC: 00 = PC+4, 01 = branch target, 10 = jump target
//   mdr_we       load-data register enable
//   rf_we        register-file write enable
//   rd_in_sel    write-back source: 1 = MDR, 0 = ALU/shift
//   state_o      current state encoding
//   trap         sticky trap flag
//   trap_cause   01 = illegal opcode, 10 = bus timeout, 11 = overflow
//   retire       one-cycle pulse when an instruction completes
module mc_controller #(
   parameter int unsigned TIMEOUT  = 255,
   parameter bit          OVF_TRAP = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mc_controller_if.master         bus,
   input  logic                    overflow,
   input  logic                    branch_taken,
   output logic [31:0]             ir,
   output logic                    pc_we,
   output logic [1:0]              pc_src,
   output logic                    mdr_we,
   output logic                    rf_we,
   output logic                    rd_in_sel,
   output logic [2:0]              state_o,
   output logic                    trap,
   output logic [1:0]              trap_cause,
   output logic                    retire
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam logic [1:0] CAUSE_OVF     = 2'b11;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   state_t        state;
   logic [31:0]   ir_q;
   logic [1:0]    trap_cause_q;
   logic [CW-1:0] wait_cnt;
   logic          ovf_q;

   logic [5:0] op;
   logic [5:0] func;
   logic       is_rtype;
   logic       is_branch;
   logic       is_jump;
   logic       is_imm;
   logic       is_clz;
   logic       is_se;
   logic       is_lw;
   logic       is_sw;
   logic       is_legal;
   logic       is_ovf_op;

   // Instruction classification from the latched IR. Only the opcode field
   // selects the class; the function field matters solely for picking out the
   // signed R-type adds/subtracts whose overflow is architecturally visible.
   always_comb begin
      op        = ir_q[31:26];
      func      = ir_q[5:0];
      is_rtype  = (op == 6'b000000);
      is_branch = (op == 6'b000001) || (op[5:2] == 4'b0001);
      is_jump   = (op[5:1] == 5'b00001);
      is_imm    = (op[5:3] == 3'b001);
      is_clz    = (op == 6'b011100);
      is_se     = (op == 6'b011111);
      is_lw     = (op == 6'b100011);
      is_sw     = (op == 6'b101011);
      is_legal  = is_rtype | is_branch | is_jump | is_imm |
                  is_clz | is_se | is_lw | is_sw;
      is_ovf_op = (is_rtype && ((func == 6'b100000) || (func == 6'b100010))) ||
                  (op == 6'b001000);
   end

   // Sequencer. Besides the state itself this block owns the IR, the trap
   // cause, the overflow flag carried from EXEC to WB and the wait-state
   // watchdog. The watchdog is cleared on every transition so it always starts
   // from zero on entry to FETCH or MEM; it only counts while a request is
   // outstanding without mem_ready. Because reaching TO_VAL forces the exit to
   // TRAP, the counter never climbs past TIMEOUT and cannot wrap. A late
   // mem_ready in the very cycle the count hits TIMEOUT still completes the
   // access, so the ready checks come before the timeout checks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         ir_q         <= 32'd0;
         trap_cause_q <= 2'b00;
         wait_cnt     <= '0;
         ovf_q        <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               wait_cnt <= '0;
               state    <= FETCH;
            end

            FETCH: begin
               if (bus.mem_ready) begin
                  ir_q     <= bus.mem_rdata;
                  wait_cnt <= '0;
                  state    <= DECODE;
               end else if (wait_cnt == TO_VAL) begin
                  trap_cause_q <= CAUSE_TIMEOUT;
                  wait_cnt     <= '0;
                  state        <= TRAP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            DECODE: begin
               if (is_legal) begin
                  state <= EXEC;
               end else begin
                  trap_cause_q <= CAUSE_ILLEGAL;
                  state        <= TRAP;
               end
            end

            EXEC: begin
               wait_cnt <= '0;
               ovf_q    <= overflow & is_ovf_op;
               if (is_branch || is_jump) begin
                  state <= FETCH;
               end else if (is_lw || is_sw) begin
                  state <= MEM;
               end else begin
                  state <= WB;
               end
            end

            MEM: begin
               if (bus.mem_ready) begin
                  wait_cnt <= '0;
                  state    <= is_sw ? FETCH : WB;
               end else if (wait_cnt == TO_VAL) begin
                  trap_cause_q <= CAUSE_TIMEOUT;
                  wait_cnt     <= '0;
                  state        <= TRAP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            WB: begin
               wait_cnt <= '0;
               if (ovf_q && OVF_TRAP) begin
                  trap_cause_q <= CAUSE_OVF;
                  state        <= TRAP;
               end else begin
                  state <= FETCH;
               end
            end

            TRAP: begin
               state <= TRAP;
            end

            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   // Datapath control decode. Everything is a function of the registered
   // state and IR, except the completion-dependent enables: the PC update in
   // FETCH and the MDR load / store retire in MEM follow mem_ready so that a
   // zero-wait access finishes in a single cycle. Branch/jump retire in EXEC
   // and the branch PC write follows the datapath's branch condition. Since
   // reset forces BOOT asynchronously, mem_req drops as soon as rst_n falls.
   always_comb begin
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.addr_sel = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SEQ;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      rd_in_sel    = 1'b0;
      retire       = 1'b0;
      trap         = 1'b0;

      case (state)
         FETCH: begin
            bus.mem_req = 1'b1;
            pc_we       = bus.mem_ready;
         end

         EXEC: begin
            if (is_branch) begin
               pc_we  = branch_taken;
               pc_src = PC_BRANCH;
               retire = 1'b1;
            end else if (is_jump) begin
               pc_we  = 1'b1;
               pc_src = PC_JUMP;
               retire = 1'b1;
            end
         end

         MEM: begin
            bus.mem_req  = 1'b1;
            bus.addr_sel = 1'b1;
            bus.mem_we   = is_sw;
            if (bus.mem_ready) begin
               retire = is_sw;
               mdr_we = is_lw;
            end
         end

         WB: begin
            rd_in_sel = is_lw;
            if (!(ovf_q && OVF_TRAP)) begin
               rf_we  = ~ovf_q;
               retire = 1'b1;
            end
         end

         TRAP: begin
            trap = 1'b1;
         end

         default: begin
         end
      endcase
   end

   assign ir         = ir_q;
   assign state_o    = state;
   assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Directed bench for mc_controller. Two instances share one stimulus stream:
// dut0 traps on overflow, dut1 only suppresses the write. Both use a short
// watchdog so the timeout path is reachable in a few cycles. A table of
// per-cycle records walks a small program from reset; hand-written sequences
// then cover reset, illegal opcode, watchdog and asynchronous-reset cases.
module tb_mc_controller;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       mdr_we;
      logic       rf_we;
      logic       rd_in_sel;
      logic       retire;
      logic       trap;
      logic [1:0] cause;
   } outs_t;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        ready;
      logic        ovf;
      logic        taken;
      outs_t       exp0;
      outs_t       exp1;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        overflow;
   logic        branch_taken;

   logic [31:0] ir0, ir1;
   logic        pc_we0, pc_we1;
   logic [1:0]  pc_src0, pc_src1;
   logic        mdr_we0, mdr_we1;
   logic        rf_we0, rf_we1;
   logic        rd_in_sel0, rd_in_sel1;
   logic [2:0]  state0, state1;
   logic        trap0, trap1;
   logic [1:0]  cause0, cause1;
   logic        retire0, retire1;

   int errors;
   int checks;
   vec_t vecs[$];

   mc_controller_if bus0 ();
   mc_controller_if bus1 ();

   assign bus0.mem_rdata = mem_rdata;
   assign bus0.mem_ready = mem_ready;
   assign bus1.mem_rdata = mem_rdata;
   assign bus1.mem_ready = mem_ready;

   mc_controller #(.TIMEOUT(TO), .OVF_TRAP(1'b1)) dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus0),
      .overflow     (overflow),
      .branch_taken (branch_taken),
      .ir           (ir0),
      .pc_we        (pc_we0),
      .pc_src       (pc_src0),
      .mdr_we       (mdr_we0),
      .rf_we        (rf_we0),
      .rd_in_sel    (rd_in_sel0),
      .state_o      (state0),
      .trap         (trap0),
      .trap_cause   (cause0),
      .retire       (retire0)
   );

   mc_controller #(.TIMEOUT(TO), .OVF_TRAP(1'b0)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus1),
      .overflow     (overflow),
      .branch_taken (branch_taken),
      .ir           (ir1),
      .pc_we        (pc_we1),
      .pc_src       (pc_src1),
      .mdr_we       (mdr_we1),
      .rf_we        (rf_we1),
      .rd_in_sel    (rd_in_sel1),
      .state_o      (state1),
      .trap         (trap1),
      .trap_cause   (cause1),
      .retire       (retire1)
   );

   // 10-unit clock; stimulus changes on the falling edge, checks 1 unit later.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case anything stalls the stimulus thread.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   function automatic outs_t o(input logic [2:0] st, input logic req, input logic we,
                               input logic asel, input logic pcwe, input logic [1:0] psrc,
                               input logic mdr, input logic rfwe, input logic rdsel,
                               input logic ret, input logic trp, input logic [1:0] cs);
      outs_t r;
      r = {st, req, we, asel, pcwe, psrc, mdr, rfwe, rdsel, ret, trp, cs};
      return r;
   endfunction

   function automatic outs_t actual0();
      return {state0, bus0.mem_req, bus0.mem_we, bus0.addr_sel, pc_we0, pc_src0,
              mdr_we0, rf_we0, rd_in_sel0, retire0, trap0, cause0};
   endfunction

   function automatic outs_t actual1();
      return {state1, bus1.mem_req, bus1.mem_we, bus1.addr_sel, pc_we1, pc_src1,
              mdr_we1, rf_we1, rd_in_sel1, retire1, trap1, cause1};
   endfunction

   task automatic add_vec2(input string nm, input logic [31:0] rd, input logic rdy,
                           input logic ovf, input logic tk, input outs_t e0, input outs_t e1);
      vec_t v;
      v.name  = nm;
      v.rdata = rd;
      v.ready = rdy;
      v.ovf   = ovf;
      v.taken = tk;
      v.exp0  = e0;
      v.exp1  = e1;
      vecs.push_back(v);
   endtask

   task automatic add_vec(input string nm, input logic [31:0] rd, input logic rdy,
                          input logic ovf, input logic tk, input outs_t e);
      add_vec2(nm, rd, rdy, ovf, tk, e, e);
   endtask

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] rd, input logic rdy,
                                 input logic ovf, input logic tk);
      mem_rdata    = rd;
      mem_ready    = rdy;
      overflow     = ovf;
      branch_taken = tk;
   endtask

   task automatic check_output(input string nm, input outs_t exp0, input outs_t exp1);
      check_val({nm, " dut0"}, 32'(actual0()), 32'(exp0));
      check_val({nm, " dut1"}, 32'(actual1()), 32'(exp1));
   endtask

   // Advance to the next falling edge, i.e. into the low phase of the next cycle.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_LW   = 32'h8C22_0004;
   localparam logic [31:0] I_BEQ  = 32'h1022_0003;
   localparam logic [31:0] I_SW   = 32'hAC22_0008;
   localparam logic [31:0] I_J    = 32'h0800_0010;
   localparam logic [31:0] I_ADDI = 32'h2022_0001;
   localparam logic [31:0] I_ILL  = 32'hFC00_0000;

   initial begin
      outs_t idle_boot, idle_dec, idle_exec, fetch_wait, fetch_done, mem_wait;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0);

      //          st  req we as pcwe src mdr rf rd ret trp cause
      idle_boot  = o(3'd0,0,0,0,0,2'b00,0,0,0,0,0,2'b00);
      idle_dec   = o(3'd2,0,0,0,0,2'b00,0,0,0,0,0,2'b00);
      idle_exec  = o(3'd3,0,0,0,0,2'b00,0,0,0,0,0,2'b00);
      fetch_wait = o(3'd1,1,0,0,0,2'b00,0,0,0,0,0,2'b00);
      fetch_done = o(3'd1,1,0,0,1,2'b00,0,0,0,0,0,2'b00);
      mem_wait   = o(3'd4,1,0,1,0,2'b00,0,0,0,0,0,2'b00);

      // Program walked cycle by cycle from the first cycle after reset release.
      add_vec("boot",        32'd0,  0,0,0, idle_boot);
      add_vec("add fetch",   I_ADD,  1,0,0, fetch_done);
      add_vec("add decode",  32'd0,  0,0,0, idle_dec);
      add_vec("add exec",    32'd0,  0,0,0, idle_exec);
      add_vec("add wb",      32'd0,  0,0,0, o(3'd5,0,0,0,0,2'b00,0,1,0,1,0,2'b00));
      add_vec("lw fetch",    I_LW,   1,0,0, fetch_done);
      add_vec("lw decode",   32'd0,  0,0,0, idle_dec);
      add_vec("lw exec",     32'd0,  0,0,0, idle_exec);
      add_vec("lw mem w1",   32'd0,  0,0,0, mem_wait);
      add_vec("lw mem w2",   32'd0,  0,0,0, mem_wait);
      add_vec("lw mem w3",   32'd0,  0,0,0, mem_wait);
      add_vec("lw mem done", 32'h55, 1,0,0, o(3'd4,1,0,1,0,2'b00,1,0,0,0,0,2'b00));
      add_vec("lw wb",       32'd0,  0,0,0, o(3'd5,0,0,0,0,2'b00,0,1,1,1,0,2'b00));
      add_vec("beq t fetch", I_BEQ,  1,0,0, fetch_done);
      add_vec("beq t dec",   32'd0,  0,0,0, idle_dec);
      add_vec("beq t exec",  32'd0,  0,0,1, o(3'd3,0,0,0,1,2'b01,0,0,0,1,0,2'b00));
      add_vec("beq n fetch", I_BEQ,  1,0,0, fetch_done);
      add_vec("beq n dec",   32'd0,  0,0,0, idle_dec);
      add_vec("beq n exec",  32'd0,  0,0,0, o(3'd3,0,0,0,0,2'b01,0,0,0,1,0,2'b00));
      add_vec("sw fetch",    I_SW,   1,0,0, fetch_done);
      add_vec("sw decode",   32'd0,  0,0,0, idle_dec);
      add_vec("sw exec",     32'd0,  0,0,0, idle_exec);
      add_vec("sw mem",      32'd0,  1,0,0, o(3'd4,1,1,1,0,2'b00,0,0,0,1,0,2'b00));
      add_vec("j fetch w",   32'd0,  0,0,0, fetch_wait);
      add_vec("j fetch",     I_J,    1,0,0, fetch_done);
      add_vec("j decode",    32'd0,  0,0,0, idle_dec);
      add_vec("j exec",      32'd0,  0,0,0, o(3'd3,0,0,0,1,2'b10,0,0,0,1,0,2'b00));
      add_vec("addi fetch",  I_ADDI, 1,0,0, fetch_done);
      add_vec("addi decode", 32'd0,  0,0,0, idle_dec);
      add_vec("addi exec",   32'd0,  0,1,0, idle_exec);
      add_vec2("addi wb",    32'd0,  0,0,0,
               o(3'd5,0,0,0,0,2'b00,0,0,0,0,0,2'b00),
               o(3'd5,0,0,0,0,2'b00,0,0,0,1,0,2'b00));
      add_vec2("ovf trap",   32'd0,  0,0,0,
               o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b11), fetch_wait);
      add_vec2("ovf trap2",  I_ADD,  1,0,0,
               o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b11), fetch_done);

      next_cycle();
      next_cycle();
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].rdata, vecs[i].ready, vecs[i].ovf, vecs[i].taken);
         #1;
         check_output(vecs[i].name, vecs[i].exp0, vecs[i].exp1);
         next_cycle();
      end

      // Reset out of TRAP (dut0) and mid-pipeline (dut1, which just fetched ADD).
      check_val("dut1 ir after fetch", ir1, I_ADD);
      rst_n = 1'b0;
      #1;
      check_output("reset", idle_boot, idle_boot);
      check_val("reset ir", ir0, 32'd0);
      check_val("reset ir dut1", ir1, 32'd0);
      next_cycle();

      // Illegal opcode: TRAP right after DECODE, memory stays idle afterwards.
      rst_n = 1'b1;
      apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      apply_stimulus(I_ILL, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("ill fetch", fetch_done, fetch_done);
      next_cycle();
      apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check_output("ill decode", idle_dec, idle_dec);
      check_val("ill ir", ir0, I_ILL);
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0);
         #1;
         check_output("ill trap", o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b01),
                      o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b01));
         check_val("ill ir frozen", ir0, I_ILL);
         next_cycle();
      end

      // Watchdog: five FETCH cycles without mem_ready, then TRAP cause 10.
      do_reset();
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         #1;
         check_output("to fetch", fetch_wait, fetch_wait);
         next_cycle();
      end
      #1;
      check_output("to trap", o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b10),
                   o(3'd6,0,0,0,0,2'b00,0,0,0,0,1,2'b10));
      next_cycle();

      // Watchdog boundary: mem_ready on the fifth cycle wins over the timeout.
      do_reset();
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         #1;
         check_output("edge fetch", fetch_wait, fetch_wait);
         next_cycle();
      end
      apply_stimulus(I_ADD, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("edge ready", fetch_done, fetch_done);
      next_cycle();
      apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0);
      #1;
      check_output("edge decode", idle_dec, idle_dec);
      next_cycle();

      // Asynchronous reset while a fetch is outstanding drops mem_req at once.
      do_reset();
      next_cycle();
      #1;
      check_output("async pre", fetch_wait, fetch_wait);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async rst", idle_boot, idle_boot);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
